manual_drive_ctrl: RTL and testbench
====================================

# manual_drive_ctrl

Sequencing controller for the car simulation's manual-driving mode. It owns the 2-bit driving state (power-off / not-starting / starting / moving) and advances it from the driver's power buttons and pedal/lever inputs. It decodes the registered state into the motion and turn commands consumed by the chassis and indicator logic. It sits between the debounced driver inputs and the motion/display datapath.

## Interface
- `HOLD_CYCLES`, default 100_000_000: consecutive cycles `power_on` must be held to power up (1 s at 100 MHz).
- `BLINK_CYCLES`, default 50_000_000: indicator half-period in cycles; used only with `TURN_BLINK_EN`.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `power_on` in 1: power-on button, active-high level.
- `power_off` in 1: power-off button, active-high level.
- `throttle`, `clutch`, `brake` in 1 each: pedal levels, active-high.
- `reverse` in 1: reverse-gear lever level (1 = reverse).
- `left`, `right` in 1 each: turn-lever levels.
- `state` out 2: current state; 00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING.
- `power_led` out 1: high when `state` is not OFF.
- `move_forward`, `move_backward` out 1 each: motion commands.
- `turn_left`, `turn_right` out 1 each: steering commands.
- `ind_left`, `ind_right` out 1 each: turn-indicator lamps.

## Operation
- **Registers:** `state` (2 bits); `hold_cnt`, wide enough for `HOLD_CYCLES`, saturating; `reverse_q`, `left_q`, `right_q`, sampled every cycle; `blink_cnt` and `blink_ph` when `TURN_BLINK_EN` is defined.
- **Reverse toggle:** `rev_tgl = reverse ^ reverse_q`.
- **Next-state priority,** evaluated every cycle:
  - `power_off` high → OFF, from any state.
  - OFF: stays OFF until `hold_cnt` reaches `HOLD_CYCLES - 1` with `power_on` still high; that cycle → NOT_STARTING.
    - `hold_cnt` increments while `power_on` is high.
    - `hold_cnt` clears when `power_on` is low or `state` is not OFF.
  - NOT_STARTING:
    - `throttle & ~clutch` → OFF (stall).
    - else `throttle & clutch & ~brake` → STARTING.
    - else hold.
  - STARTING:
    - `brake` → NOT_STARTING.
    - else `throttle & ~clutch` → MOVING.
    - else hold.
  - MOVING:
    - `brake` → NOT_STARTING.
    - else `rev_tgl & ~clutch` → OFF.
    - else `clutch | ~throttle` → STARTING.
    - else hold.
  - `rev_tgl` with `clutch` high is a legal gear change in every state; no transition.
- **Output decode** is combinational from registers only; there is no input-to-output combinational path.
  - `move_forward = (state==MOVING) & ~reverse_q`.
  - `move_backward = (state==MOVING) & reverse_q`.
  - `turn_left = (state!=OFF) & left_q & ~right_q`.
  - `turn_right = (state!=OFF) & right_q & ~left_q`.
  - `left_q` and `right_q` both high → no turn.
  - `power_led = (state!=OFF)`.
  - Indicators: see Configuration.

## Timing
- **Reset** (`rst_n` low at an edge):
  - `state` = OFF, `hold_cnt` = 0, `blink_cnt` = 0, `blink_ph` = 0.
  - `reverse_q`, `left_q`, `right_q` load the live inputs, so no false toggle occurs on release.
  - All outputs 0 while in reset.
- **Reset mid-operation:** any state → OFF on that edge. A power-on hold in progress restarts from 0.
- **Latency:** an input sampled at edge k is reflected in `state` and all outputs after edge k, i.e. 1 cycle.
- **Power-up latency:** NOT_STARTING is visible exactly `HOLD_CYCLES` edges after `power_on` is first sampled high.
- **Simultaneous events:**
  - `power_off` beats everything.
  - `brake` beats reverse-stall and throttle.
  - `power_on` and `power_off` both high → OFF, and `hold_cnt` still counts.
  - Stall on toggle fires on the same edge the toggle is sampled.

## Configuration
- Macro: `TURN_BLINK_EN`.
- **Defined:**
  - `blink_cnt` counts 0..`BLINK_CYCLES-1` and wraps.
  - `blink_ph` flips on each wrap.
  - The counter and phase clear whenever neither `turn_left` nor `turn_right` is active, so the lamp starts lit.
  - `ind_left = turn_left & ~blink_ph`; `ind_right = turn_right & ~blink_ph`.
- **Undefined:** no blink registers; `ind_left = turn_left`, `ind_right = turn_right` (steady).

## Test plan
- **Power-up:** `HOLD_CYCLES=8`. Hold `power_on` 7 cycles, release → stays 00. Hold 8 cycles → `state`=01 and `power_led`=1 after the 8th edge.
- **Start and drive:**
  - From 01: `throttle`=1, `clutch`=1 → 10.
  - Release `clutch` → 11 with `move_forward`=1.
  - `brake`=1 → 01 and `move_forward`=0.
- **Stall:**
  - From 01: `throttle`=1, `clutch`=0 → 00 next cycle.
  - From 11: flip `reverse` with `clutch`=0 → 00.
  - Flip with `clutch`=1 → no stall; next cycle `move_backward` reflects the new `reverse_q`.
- **Priority:**
  - In 11, assert `power_off` and `brake` together → 00.
  - Assert `brake` and a reverse flip without clutch → 01.
- **Reset mid-operation:** in 11 with `reverse`=1, pulse `rst_n` low 1 cycle → 00 and all outputs 0. After reset, `rev_tgl` stays 0.
- **Turn and blink:** `TURN_BLINK_EN` defined, `BLINK_CYCLES=4`, state 01, `left`=1 → `ind_left` pattern 1111 0000 repeating. `left`=`right`=1 → both `turn_*` and `ind_*` are 0. Macro undefined → `ind_left` steady 1.

Source files
------------

// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl: manual-driving state sequencer with motion/turn/indicator decode.
// Define TURN_BLINK_EN for blinking indicators; otherwise the indicators follow the turn commands steadily.
module manual_drive_ctrl #(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       power_off,
    input  logic       throttle,
    input  logic       clutch,
    input  logic       brake,
    input  logic       reverse,
    input  logic       left,
    input  logic       right,
    output logic [1:0] state,
    output logic       power_led,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       ind_left,
    output logic       ind_right
);
    typedef enum logic [1:0] {OFF = 2'b00, NOT_STARTING = 2'b01, STARTING = 2'b10, MOVING = 2'b11} state_t;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    state_t st, st_nxt;
    logic [HW-1:0] hold_cnt;
    logic reverse_q, left_q, right_q, rev_tgl, hold_done;
    assign rev_tgl   = reverse ^ reverse_q;
    assign hold_done = power_on && hold_cnt == HW'(HOLD_CYCLES - 1);
    // Lever samples load the live inputs even in reset so release never sees a false toggle.
    always_ff @(posedge clk) begin
        reverse_q <= reverse;
        left_q    <= left;
        right_q   <= right;
        if (!rst_n) begin
            st       <= OFF;
            hold_cnt <= '0;
        end else begin
            st       <= st_nxt;
            hold_cnt <= (power_on && st == OFF) ? (hold_done ? hold_cnt : hold_cnt + 1'b1) : '0;
        end
    end
    always_comb begin
        st_nxt = st;
        if (power_off)
            st_nxt = OFF;
        else
            case (st)
                OFF:          st_nxt = hold_done ? NOT_STARTING : OFF;
                NOT_STARTING: st_nxt = (throttle && !clutch) ? OFF :
                                       (throttle && clutch && !brake) ? STARTING : NOT_STARTING;
                STARTING:     st_nxt = brake ? NOT_STARTING :
                                       (throttle && !clutch) ? MOVING : STARTING;
                MOVING:       st_nxt = brake ? NOT_STARTING :
                                       (rev_tgl && !clutch) ? OFF :
                                       (clutch || !throttle) ? STARTING : MOVING;
                default:      st_nxt = OFF;
            endcase
    end
    assign state         = st;
    assign power_led     = st != OFF;
    assign move_forward  = st == MOVING && !reverse_q;
    assign move_backward = st == MOVING && reverse_q;
    assign turn_left     = st != OFF && left_q && !right_q;
    assign turn_right    = st != OFF && right_q && !left_q;
`ifdef TURN_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BW-1:0] blink_cnt;
    logic blink_ph, blink_wrap;
    assign blink_wrap = blink_cnt == BW'(BLINK_CYCLES - 1);
    // Idle clears the phase so every new turn starts with the lamp lit.
    always_ff @(posedge clk) begin
        if (!rst_n || !(turn_left || turn_right)) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_ph  <= blink_ph ^ blink_wrap;
        end
    end
    assign ind_left  = turn_left && !blink_ph;
    assign ind_right = turn_right && !blink_ph;
`else
    assign ind_left  = turn_left;
    assign ind_right = turn_right;
`endif
endmodule

// File: tb/tb_manual_drive_ctrl.sv
// tb_manual_drive_ctrl: directed checks of power-up, drive, stall, priority, reset and turn decode.
module tb_manual_drive_ctrl;
    logic clk = 1'b0;
    logic rst_n, power_on, power_off, throttle, clutch, brake, reverse, left, right;
    logic [1:0] state;
    logic power_led, move_forward, move_backward, turn_left, turn_right, ind_left, ind_right;
    int errors = 0;
    int checks = 0;

    manual_drive_ctrl #(.HOLD_CYCLES(8), .BLINK_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .power_on(power_on), .power_off(power_off),
        .throttle(throttle), .clutch(clutch), .brake(brake), .reverse(reverse),
        .left(left), .right(right), .state(state), .power_led(power_led),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right),
        .ind_left(ind_left), .ind_right(ind_right)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic power_up();
        power_on = 1'b1;
        step(8);
        power_on = 1'b0;
    endtask

    task automatic drive_to_moving();
        throttle = 1'b1; clutch = 1'b1;
        step(1);
        clutch = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; power_on = 1'b0; power_off = 1'b0; throttle = 1'b0; clutch = 1'b0;
        brake = 1'b0; reverse = 1'b0; left = 1'b0; right = 1'b0;
        step(2);
        chk("reset_state", state, 2'b00);
        chk("reset_led", {1'b0, power_led}, 2'b00);
        chk("reset_move", {move_forward, move_backward}, 2'b00);
        chk("reset_ind", {ind_left, ind_right}, 2'b00);
        rst_n = 1'b1;
        // power-up: 7 edges not enough, 8 edges enough
        power_on = 1'b1;
        step(7);
        power_on = 1'b0;
        chk("hold7_state", state, 2'b00);
        step(1);
        chk("hold7_release", state, 2'b00);
        power_on = 1'b1;
        step(7);
        chk("hold8_before", state, 2'b00);
        step(1);
        power_on = 1'b0;
        chk("hold8_state", state, 2'b01);
        chk("hold8_led", {1'b0, power_led}, 2'b01);
        // start and drive
        throttle = 1'b1; clutch = 1'b1;
        step(1);
        chk("start_state", state, 2'b10);
        clutch = 1'b0;
        step(1);
        chk("moving_state", state, 2'b11);
        chk("moving_fwd", {move_forward, move_backward}, 2'b10);
        brake = 1'b1;
        step(1);
        chk("brake_state", state, 2'b01);
        chk("brake_move", {move_forward, move_backward}, 2'b00);
        brake = 1'b0;
        // stall from NOT_STARTING
        step(1);
        chk("stall01_state", state, 2'b00);
        throttle = 1'b0;
        // stall on reverse flip without clutch
        power_up();
        drive_to_moving();
        chk("moving2_state", state, 2'b11);
        reverse = 1'b1;
        step(1);
        chk("rev_stall_state", state, 2'b00);
        throttle = 1'b0;
        // gear change with clutch held: no stall
        power_up();
        drive_to_moving();
        chk("moving3_back", {move_forward, move_backward}, 2'b01);
        reverse = 1'b0; clutch = 1'b1;
        step(1);
        chk("gear_chg_state", state, 2'b10);
        clutch = 1'b0;
        step(1);
        chk("gear_chg_moving", state, 2'b11);
        chk("gear_chg_fwd", {move_forward, move_backward}, 2'b10);
        // power_off beats brake
        power_off = 1'b1; brake = 1'b1;
        step(1);
        chk("poff_brake_state", state, 2'b00);
        power_off = 1'b0; brake = 1'b0; throttle = 1'b0;
        // brake beats reverse stall
        power_up();
        drive_to_moving();
        brake = 1'b1; reverse = 1'b1;
        step(1);
        chk("brake_rev_state", state, 2'b01);
        brake = 1'b0; throttle = 1'b0;
        // power_on and power_off together: OFF while hold still counts
        power_on = 1'b1; power_off = 1'b1;
        step(10);
        chk("both_btn_state", state, 2'b00);
        power_off = 1'b0;
        step(1);
        power_on = 1'b0;
        chk("both_btn_release", state, 2'b01);
        // reset mid-operation in MOVING with reverse high
        drive_to_moving();
        chk("pre_rst_back", {move_forward, move_backward}, 2'b01);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_state", state, 2'b00);
        chk("mid_rst_move", {move_forward, move_backward}, 2'b00);
        chk("mid_rst_led", {1'b0, power_led}, 2'b00);
        rst_n = 1'b1; throttle = 1'b0;
        step(1);
        chk("post_rst_state", state, 2'b00);
        // reset restarts a hold in progress
        power_on = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(7);
        chk("hold_restart_before", state, 2'b00);
        step(1);
        power_on = 1'b0;
        chk("hold_restart_after", state, 2'b01);
        // turn decode and indicator
        left = 1'b1;
        step(1);
        chk("turn_left", {turn_left, turn_right}, 2'b10);
        for (int i = 0; i < 12; i++) begin
`ifdef TURN_BLINK_EN
            chk($sformatf("ind_left_blink_%0d", i), {1'b0, ind_left}, {1'b0, ((i / 4) % 2) == 0});
`else
            chk($sformatf("ind_left_steady_%0d", i), {1'b0, ind_left}, 2'b01);
`endif
            step(1);
        end
        right = 1'b1;
        step(1);
        chk("both_lever_turn", {turn_left, turn_right}, 2'b00);
        chk("both_lever_ind", {ind_left, ind_right}, 2'b00);
        left = 1'b0;
        step(1);
        chk("turn_right", {turn_left, turn_right}, 2'b01);
        chk("ind_right_first", {ind_left, ind_right}, 2'b01);
        power_off = 1'b1;
        step(1);
        chk("off_no_turn", {turn_left, turn_right}, 2'b00);
        chk("off_no_ind", {ind_left, ind_right}, 2'b00);
        power_off = 1'b0; right = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
